seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Iterative restoring divider that returns quotient and remainder for signed or unsigned operands.
- It is the sequential counterpart of the combinational modulo and sign-extension helpers in the datapath: operands are reduced over WIDTH cycles.
- Sits beside the ALU and is driven by the control unit through a start/busy/done handshake.

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits (minimum 2)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request a division; sampled only while busy=0
dividend  input  WIDTH  dividend operand, captured on the accepting edge
divisor  input  WIDTH  divisor operand, captured on the accepting edge
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with the operands
busy  output  1  high whenever the FSM is not in IDLE
done  output  1  single-cycle pulse: result outputs are valid and updated
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
div_by_zero  output  1  registered flag: last result had divisor = 0

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - busy, done, quotient, remainder, div_by_zero all 0.
  - Iteration counter and internal registers cleared.
  - Any in-flight operation is abandoned with no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE -> CALC at edge E0 when start=1.
  - Capture is_signed.
  - Capture |dividend| and |divisor|; magnitudes are taken only when is_signed=1, otherwise the raw values.
  - Capture sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend), both forced to 0 when unsigned.
  - Partial remainder = 0; counter = WIDTH.
- CALC (exactly WIDTH cycles, edges E1..E_WIDTH):
  - Shift {partial remainder, dividend register} left by 1.
  - Trial-subtract the divisor magnitude using a WIDTH+1-bit subtractor.
  - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter; at counter reaching 0, go to FIX.
- FIX (1 cycle, edge E_WIDTH+1):
  - Negate the quotient if sign_q=1 and the remainder if sign_r=1, as two's complement modulo 2^WIDTH.
  - Load quotient/remainder outputs, set div_by_zero, assert done; go to DONE.
- DONE (1 cycle): done=1, busy=1. Next edge: done=0, go to IDLE.
- Latency:
  - Fixed at WIDTH+1 edges from the accepting edge E0 to done rising.
  - For WIDTH=8, done is high during the cycle after E9.
  - busy is high from E0 until the edge leaving DONE.
- Outputs: quotient, remainder and div_by_zero hold their value between done pulses and change only on the edge that raises done.
- start while busy=1 (including the DONE cycle) is ignored, with no queuing. A new start is accepted on the first edge in IDLE.
- Signed semantics: truncating division. Quotient rounds toward zero; remainder carries the sign of the dividend; dividend = quotient*divisor + remainder.
- Divisor = 0:
  - Same fixed latency.
  - quotient = all ones.
  - remainder = dividend as supplied, no sign processing.
  - div_by_zero = 1.
  - Applies for both signed and unsigned.
- Signed overflow: most-negative / -1 gives quotient = most-negative (wraps), remainder = 0, div_by_zero = 0.
- Inputs dividend, divisor and is_signed may change freely after E0 without affecting the operation in progress.

Test Plan:
- Unsigned 10/3, start at E0 -> done exactly 9 edges later; quotient=8'd3, remainder=8'd1, div_by_zero=0; busy high E0..E10.
- Signed -15/4 (8'hF1/8'h04) -> quotient=8'hFD (-3), remainder=8'hFD (-3). Signed 15/-4 -> quotient=8'hFD, remainder=8'h03.
- Same bits, two modes: 8'd200/8'd7 unsigned -> q=8'd28, r=8'd4. is_signed=1 (-56/7) -> q=8'hF8, r=8'h00.
- Divide by zero 5/0, unsigned and signed -> q=8'hFF, r=8'h05, div_by_zero=1, done after 9 edges. Follow with 6/2 -> div_by_zero returns to 0, q=3, r=0.
- Edge operands:
  - Signed 8'h80/8'hFF -> q=8'h80, r=0.
  - Unsigned 8'hFF/8'h01 -> q=8'hFF, r=0.
  - 0/7 -> q=0, r=0.
- Handshake and reset:
  - Pulse start during CALC and again during DONE -> ignored; exactly one done pulse.
  - Assert rst mid-CALC (cycle 4) -> busy, done, quotient, remainder, div_by_zero go to 0 immediately, and no done pulse follows.
  - After release, 9/2 -> q=4, r=1.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider for signed/unsigned operands with start/busy/done handshake
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_raw;
    logic [CW-1:0]    r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_zero;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;

    assign w_dvd_neg = is_signed & dividend[WIDTH-1];
    assign w_dvs_neg = is_signed & divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag = w_dvs_neg ? -divisor : divisor;
    // The shifted partial remainder is WIDTH+1 bits so the trial subtraction's MSB is a clean borrow
    assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state: CALC runs until the counter would hit zero, FIX and DONE last one cycle each
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? CALC : IDLE;
            CALC:    w_next = (r_cnt == CW'(1)) ? FIX : CALC;
            FIX:     w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == DONE);
    end

    // Datapath: capture magnitudes and signs, shift/subtract per bit, then sign-fix into the outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_raw       <= '0;
            r_cnt       <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_zero      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_dvd    <= w_dvd_mag;
            r_dvs    <= w_dvs_mag;
            r_rem    <= '0;
            r_raw    <= dividend;
            r_cnt    <= CW'(WIDTH);
            r_sign_q <= w_dvd_neg ^ w_dvs_neg;
            r_sign_r <= w_dvd_neg;
            r_zero   <= (divisor == '0);
        end else if (r_state == CALC) begin
            r_rem <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_dvd <= {r_dvd[WIDTH-2:0], ~w_diff[WIDTH]};
            r_cnt <= r_cnt - 1'b1;
        end else if (r_state == FIX) begin
            quotient    <= r_zero ? '1 : (r_sign_q ? -r_dvd : r_dvd);
            remainder   <= r_zero ? r_raw : (r_sign_r ? -r_rem : r_rem);
            div_by_zero <= r_zero;
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed checks of seq_divider results, latency, handshake and reset
module tb_seq_divider;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       is_signed = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;
    int         n_checks = 0;
    int         n_fail = 0;

    seq_divider #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .is_signed(is_signed), .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Drives one division; returns results, edges from E0 to done, whether busy stayed high, and busy after leaving DONE
    task automatic do_div(input logic [7:0] a, input logic [7:0] b, input logic s,
                          output logic [7:0] q, output logic [7:0] r, output logic z,
                          output int lat, output logic busy_held, output logic busy_after);
        @(negedge clk);
        dividend = a; divisor = b; is_signed = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; dividend = ~a; divisor = ~b; is_signed = ~s;
        lat = 0;
        busy_held = busy;
        while (!done && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            busy_held &= busy;
        end
        q = quotient; r = remainder; z = div_by_zero;
        @(posedge clk);
        #1;
        busy_after = busy;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_state got busy=%b done=%b q=%h r=%h z=%b want all 0", busy, done, quotient, remainder, div_by_zero);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        logic [7:0] q, r; logic z, bh, ba; int lat;
        do_div(8'd10, 8'd3, 1'b0, q, r, z, lat, bh, ba);
        n_checks++;
        if (lat !== 9) begin n_fail++; $display("FAIL u10_3_latency got %0d want 9", lat); end
        n_checks++;
        if ({q, r, z} !== {8'd3, 8'd1, 1'b0}) begin n_fail++; $display("FAIL u10_3 got q=%h r=%h z=%b want 03 01 0", q, r, z); end
        n_checks++;
        if ({bh, ba} !== 2'b10) begin n_fail++; $display("FAIL u10_3_busy got held=%b after=%b want 1 0", bh, ba); end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== {8'd3, 8'd1, 1'b0}) begin n_fail++; $display("FAIL hold got q=%h r=%h z=%b want 03 01 0", quotient, remainder, div_by_zero); end
    endtask

    task automatic test_signed();
        logic [7:0] q, r; logic z, bh, ba; int lat;
        do_div(8'hF1, 8'h04, 1'b1, q, r, z, lat, bh, ba);
        n_checks++;
        if ({q, r, z} !== {8'hFD, 8'hFD, 1'b0}) begin n_fail++; $display("FAIL s_m15_4 got q=%h r=%h z=%b want fd fd 0", q, r, z); end
        do_div(8'h0F, 8'hFC, 1'b1, q, r, z, lat, bh, ba);
        n_checks++;
        if ({q, r, z} !== {8'hFD, 8'h03, 1'b0}) begin n_fail++; $display("FAIL s_15_m4 got q=%h r=%h z=%b want fd 03 0", q, r, z); end
    endtask

    task automatic test_modes();
        logic [7:0] q, r; logic z, bh, ba; int lat;
        do_div(8'd200, 8'd7, 1'b0, q, r, z, lat, bh, ba);
        n_checks++;
        if ({q, r, z} !== {8'd28, 8'd4, 1'b0}) begin n_fail++; $display("FAIL u200_7 got q=%h r=%h z=%b want 1c 04 0", q, r, z); end
        do_div(8'd200, 8'd7, 1'b1, q, r, z, lat, bh, ba);
        n_checks++;
        if ({q, r, z} !== {8'hF8, 8'h00, 1'b0}) begin n_fail++; $display("FAIL s_m56_7 got q=%h r=%h z=%b want f8 00 0", q, r, z); end
    endtask

    task automatic test_div_zero();
        logic [7:0] q, r; logic z, bh, ba; int lat;
        do_div(8'd5, 8'd0, 1'b0, q, r, z, lat, bh, ba);
        n_checks++;
        if ({q, r, z} !== {8'hFF, 8'h05, 1'b1}) begin n_fail++; $display("FAIL u5_0 got q=%h r=%h z=%b want ff 05 1", q, r, z); end
        n_checks++;
        if (lat !== 9) begin n_fail++; $display("FAIL u5_0_latency got %0d want 9", lat); end
        do_div(8'd5, 8'd0, 1'b1, q, r, z, lat, bh, ba);
        n_checks++;
        if ({q, r, z} !== {8'hFF, 8'h05, 1'b1}) begin n_fail++; $display("FAIL s5_0 got q=%h r=%h z=%b want ff 05 1", q, r, z); end
        do_div(8'hF1, 8'd0, 1'b1, q, r, z, lat, bh, ba);
        n_checks++;
        if ({q, r, z} !== {8'hFF, 8'hF1, 1'b1}) begin n_fail++; $display("FAIL s_m15_0 got q=%h r=%h z=%b want ff f1 1", q, r, z); end
        do_div(8'd6, 8'd2, 1'b0, q, r, z, lat, bh, ba);
        n_checks++;
        if ({q, r, z} !== {8'd3, 8'd0, 1'b0}) begin n_fail++; $display("FAIL u6_2 got q=%h r=%h z=%b want 03 00 0", q, r, z); end
    endtask

    task automatic test_edges();
        logic [7:0] q, r; logic z, bh, ba; int lat;
        do_div(8'h80, 8'hFF, 1'b1, q, r, z, lat, bh, ba);
        n_checks++;
        if ({q, r, z} !== {8'h80, 8'h00, 1'b0}) begin n_fail++; $display("FAIL s_min_m1 got q=%h r=%h z=%b want 80 00 0", q, r, z); end
        do_div(8'hFF, 8'h01, 1'b0, q, r, z, lat, bh, ba);
        n_checks++;
        if ({q, r, z} !== {8'hFF, 8'h00, 1'b0}) begin n_fail++; $display("FAIL u255_1 got q=%h r=%h z=%b want ff 00 0", q, r, z); end
        do_div(8'd0, 8'd7, 1'b0, q, r, z, lat, bh, ba);
        n_checks++;
        if ({q, r, z} !== {8'd0, 8'd0, 1'b0}) begin n_fail++; $display("FAIL u0_7 got q=%h r=%h z=%b want 00 00 0", q, r, z); end
    endtask

    task automatic test_back_to_back();
        int dcnt = 0;
        int dpos = 0;
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd9; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dcnt++;
                if (dpos == 0) dpos = k;
            end
            if (k == 3) begin dividend = 8'd50; divisor = 8'd5; start = 1'b1; end
            if (k == 4 || k == 10) start = 1'b0;
            if (k == 9) start = 1'b1;
        end
        n_checks++;
        if (dcnt !== 1 || dpos !== 9) begin n_fail++; $display("FAIL ignore_start got pulses=%0d at=%0d want 1 at 9", dcnt, dpos); end
        n_checks++;
        if ({quotient, remainder} !== {8'd11, 8'd1}) begin n_fail++; $display("FAIL u100_9 got q=%h r=%h want 0b 01", quotient, remainder); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] q, r; logic z, bh, ba; int lat;
        int dcnt = 0;
        @(negedge clk);
        dividend = 8'd50; divisor = 8'd3; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
            n_fail++;
            $display("FAIL mid_reset got busy=%b done=%b q=%h r=%h z=%b want all 0", busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        n_checks++;
        if (dcnt !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL after_reset got pulses=%0d busy=%b want 0 0", dcnt, busy); end
        do_div(8'd9, 8'd2, 1'b0, q, r, z, lat, bh, ba);
        n_checks++;
        if ({q, r, z} !== {8'd4, 8'd1, 1'b0}) begin n_fail++; $display("FAIL u9_2 got q=%h r=%h z=%b want 04 01 0", q, r, z); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_modes();
        test_div_zero();
        test_edges();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
